// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-side SRAM-like bus: size encodings, bus field
// widths and the response-queue entry layout used by data_sram_responder.
package data_sram_responder_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_STRB_W = 4;
  localparam int BUS_SIZE_W = 2;

  localparam logic [BUS_SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [BUS_SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [BUS_SIZE_W-1:0] SIZE_WORD = 2'd2;

  // Wide enough for LATENCY-1 (max 14) plus the optional random extra 0..3.
  localparam int CD_W = 5;

  typedef struct packed {
    logic                  wr;
    logic [BUS_DATA_W-1:0] data;
    logic [CD_W-1:0]       cd;
  } resp_entry_t;

  function automatic logic [BUS_DATA_W-1:0] merge_bytes(
    input logic [BUS_DATA_W-1:0] old_word,
    input logic [BUS_DATA_W-1:0] new_word,
    input logic [BUS_STRB_W-1:0] strb
  );
    logic [BUS_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < BUS_STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_resp_queue.sv
// In-order response FIFO: DEPTH entries, each with a countdown that decrements
// every cycle (saturating at 0). Only the head may be popped.
module data_sram_responder_resp_queue
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  resp_entry_t                push_entry,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       head_valid,
  output resp_entry_t                head_entry
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  resp_entry_t      ent_q [DEPTH];
  resp_entry_t      ent_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].cd != '0) ent_d[i].cd = ent_q[i].cd - 1'b1;
    end
    // The freshly pushed entry takes its load value untouched by this cycle's decrement.
    if (push) ent_d[wr_ptr_q] = push_entry;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign count      = count_q;
  assign full       = (count_q == CNT_W'(DEPTH));
  assign head_valid = (count_q != '0);
  assign head_entry = ent_q[rd_ptr_q];

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM-like bus responder: word memory, request acceptance, and
// in-order delayed responses. Define SRAM_RAND_DELAY_EN for LFSR-jittered timing.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  wr,
  input  logic [BUS_SIZE_W-1:0] size,
  input  logic [BUS_ADDR_W-1:0] addr,
  input  logic [BUS_STRB_W-1:0] wstrb,
  input  logic [BUS_DATA_W-1:0] wdata,
  output logic                  addr_ok,
  output logic                  data_ok,
  output logic [BUS_DATA_W-1:0] rdata
);

  localparam logic [CD_W-1:0] CD_BASE = CD_W'(LATENCY - 1);

  logic [BUS_DATA_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0]          idx;
  logic                       accept;
  logic                       pop;
  logic                       q_full;
  logic                       q_head_valid;
  logic [$clog2(OUTSTANDING):0] q_count;
  resp_entry_t                push_entry;
  resp_entry_t                head_entry;
  logic [CD_W-1:0]            cd_load;
  logic                       gate_ok;
  logic [BUS_DATA_W-1:0]      mem_wr_word_d;

`ifdef SRAM_RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign cd_load = CD_BASE + {3'b000, lfsr_q[1:0]};
  assign gate_ok = (lfsr_q[4:2] != 3'b000);
`else
  assign cd_load = CD_BASE;
  assign gate_ok = 1'b1;
`endif

  // Word index truncation gives the modulo-depth address wrap.
  assign idx     = addr[ADDR_W+1:2];
  assign addr_ok = !q_full && gate_ok;
  assign accept  = req && addr_ok && !reset;

  // The read samples pre-edge contents; any earlier write committed on a prior edge.
  always_comb begin
    push_entry.wr   = wr;
    push_entry.data = wr ? '0 : mem[idx];
    push_entry.cd   = cd_load;
    mem_wr_word_d   = merge_bytes(mem[idx], wdata, wstrb);
  end

  always_ff @(posedge clk) begin
    if (accept && wr) mem[idx] <= mem_wr_word_d;
  end

  assign pop     = q_head_valid && (head_entry.cd == '0);
  assign data_ok = pop;
  assign rdata   = pop ? head_entry.data : '0;

  data_sram_responder_resp_queue #(
    .DEPTH (OUTSTANDING)
  ) u_resp_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (q_count),
    .full       (q_full),
    .head_valid (q_head_valid),
    .head_entry (head_entry)
  );

  // Bus fields carried without functional effect.
  logic unused_ok;
  assign unused_ok = ^{size, addr[BUS_ADDR_W-1:ADDR_W+2], addr[1:0], q_count, head_entry.wr};

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder with LATENCY=4, OUTSTANDING=4, ADDR_W=12.
module tb_data_sram_responder;

  localparam int ADDR_W      = 12;
  localparam int LATENCY     = 4;
  localparam int OUTSTANDING = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] wdata = '0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  data_sram_responder #(
    .ADDR_W      (ADDR_W),
    .LATENCY     (LATENCY),
    .OUTSTANDING (OUTSTANDING)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .addr    (addr),
    .wstrb   (wstrb),
    .wdata   (wdata),
    .addr_ok (addr_ok),
    .data_ok (data_ok),
    .rdata   (rdata)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected rdata and the cycle it must appear in.
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_cyc_q.delete();
    end else if (data_ok) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_data_ok: got data_ok=1 rdata %h expected no response (cycle %0d)",
                 rdata, cyc);
      end else begin
        logic [31:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check32("resp_rdata", rdata, e);
        check32("resp_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] e);
    int waited;
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    waited = 0;
    while (!addr_ok && waited < 50) begin
      step();
      waited++;
    end
    if (!addr_ok) begin
      check32("addr_ok_timeout", {31'd0, addr_ok}, 32'd1);
    end else begin
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + LATENCY);
      step();
    end
    req = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      step();
      waited++;
    end
    check32("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];
  logic ok_tr[40];
  logic dok_tr[40];

  initial begin
    // Hand-computed vectors, issued back to back
    vecs[0] = '{1'b1, 32'h0000_0010, 4'hF,    32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'h0000_0010, 4'h0,    32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0020, 4'hF,    32'h1122_3344, 32'h0000_0000};
    vecs[3] = '{1'b1, 32'h0000_0020, 4'b0010, 32'h0000_AA00, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h0000_0020, 4'h0,    32'h0,         32'h1122_AA44};
    vecs[5] = '{1'b1, 32'h0000_0020, 4'h0,    32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{1'b0, 32'h0000_0022, 4'h0,    32'h0,         32'h1122_AA44};
    vecs[7] = '{1'b0, 32'h0000_4010, 4'h0,    32'h0,         32'hDEAD_BEEF};
    vecs[8] = '{1'b1, 32'h0000_4031, 4'hF,    32'hCAFE_F00D, 32'h0000_0000};
    vecs[9] = '{1'b0, 32'h0000_0030, 4'h0,    32'h0,         32'hCAFE_F00D};

    repeat (3) step();
    reset = 1'b0;
    step();
    check32("reset_addr_ok", {31'd0, addr_ok}, 32'd1);
    check32("reset_data_ok", {31'd0, data_ok}, 32'd0);
    check32("reset_rdata", rdata, 32'd0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].wr, vecs[i].addr, vecs[i].strb, vecs[i].wdata, vecs[i].exp);
    end
    drain();

    // Preload words for the held-request burst
    for (int k = 0; k < 8; k++) begin
      issue(1'b1, 32'h100 + 32'(4 * k), 4'hF, 32'hA500_0000 + 32'(k), 32'h0);
    end
    drain();

    // Held req: addr_ok must drop after 4 accepts and stay low while the head completes
    begin
      int n;
      int si;
      n = 0;
      si = 0;
      req = 1'b1; wr = 1'b0; wstrb = 4'h0; wdata = '0;
      while (n < 8 && si < 40) begin
        addr = 32'h100 + 32'(4 * n);
        ok_tr[si]  = addr_ok;
        dok_tr[si] = data_ok;
        if (addr_ok) begin
          exp_q.push_back(32'hA500_0000 + 32'(n));
          exp_cyc_q.push_back(cyc + LATENCY);
        end
        step();
        if (ok_tr[si]) n++;
        si++;
      end
      req = 1'b0;
      check32("burst_accepts", 32'(n), 32'd8);
      check32("burst_ok_step3", {31'd0, ok_tr[3]}, 32'd1);
      check32("full_ok_step4", {31'd0, ok_tr[4]}, 32'd0);
      check32("full_dok_step4", {31'd0, dok_tr[4]}, 32'd1);
      check32("refill_ok_step5", {31'd0, ok_tr[5]}, 32'd1);
      check32("refill_dok_step5", {31'd0, dok_tr[5]}, 32'd1);
    end
    drain();

    // Reset with three pending reads: all dropped, memory retained
    issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEAD_BEEF);
    issue(1'b0, 32'h20, 4'h0, 32'h0, 32'h1122_AA44);
    issue(1'b0, 32'h30, 4'h0, 32'h0, 32'hCAFE_F00D);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check32("midreset_addr_ok", {31'd0, addr_ok}, 32'd1);
    check32("midreset_data_ok", {31'd0, data_ok}, 32'd0);
    check32("midreset_rdata", rdata, 32'd0);
    repeat (10) step();
    issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEAD_BEEF);
    issue(1'b0, 32'h20, 4'h0, 32'h0, 32'h1122_AA44);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Simulation/FPGA data-memory responder on the data-side SRAM-like bus. It is the target end of the bus the CPU's EX/MEM stages drive (request from EX, read data consumed in MEM).
- Accepts read/write requests with an address handshake and holds a word-organised memory array.
- Returns in-order responses with a data handshake after a programmable latency.
- Supports multiple outstanding requests, so the pipeline sees realistic, non-single-cycle memory timing.

Parameters:
- ADDR_W, 12, word-index width; memory depth = 2**ADDR_W words.
- LATENCY, 2, minimum cycles from request acceptance to data_ok; legal range 1..15.
- OUTSTANDING, 4, maximum accepted-but-unanswered requests; power of 2, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- req  input  1  request valid.
- wr  input  1  1 = write, 0 = read.
- size  input  2  0 = byte, 1 = half, 2 = word; carried only, no functional effect.
- addr  input  32  byte address; word index = addr[ADDR_W+1:2].
- wstrb  input  4  byte-lane write enables; wstrb[i] writes byte i.
- wdata  input  32  write data, lane-aligned.
- addr_ok  output  1  request accepted this cycle when req is also high.
- data_ok  output  1  one response completes this cycle.
- rdata  output  32  read data; valid only while data_ok is high.

Behaviour:
- Reset: clk and reset only (synchronous, active-high). Reset clears the response queue (count = 0, pointers = 0). Memory contents are not cleared. In the cycle after reset: addr_ok = 1, data_ok = 0, rdata = 0.
- Acceptance:
  - A request is accepted on a rising edge where req && addr_ok.
  - addr_ok = (count < OUTSTANDING), a registered-state function only. It never depends combinationally on req.
  - No full-queue bypass: a completion in the same cycle does not raise addr_ok.
- Write commit:
  - Happens at the accepting edge: mem[idx] byte i <= wdata byte i for each wstrb[i] = 1.
  - wstrb = 0 leaves memory unchanged.
- Read sampling:
  - Happens at the accepting edge, after all earlier writes have committed.
  - A read accepted in the same cycle as no earlier write sees the pre-edge contents. Read-after-write ordering is therefore in request order.
- Queue entry on acceptance:
  - Each accepted request pushes {wr, read word, countdown = LATENCY-1}. Write entries store rdata = 0.
  - All entry countdowns decrement each cycle, saturating at 0.
- Completion:
  - data_ok = (count != 0) && (head countdown == 0). rdata = head data.
  - The head pops on that edge. There is no stall input: the CPU side must always accept data_ok.
- Timing:
  - A request accepted at edge t (empty queue) gives data_ok high in the cycle following edge t+LATENCY-1, i.e. exactly LATENCY cycles after acceptance.
  - Back-to-back acceptances give back-to-back data_ok pulses; throughput is 1 per cycle.
  - Responses are strictly in acceptance order; at most one data_ok per cycle.
- Count: simultaneous push and pop leaves count unchanged. count never exceeds OUTSTANDING and never goes below 0.
- Address wrap: addresses beyond the array wrap modulo depth via truncation of the word index. addr[1:0] is ignored.
- Reset mid-operation: pending responses are dropped silently (no data_ok). Writes already accepted remain in memory.

Optional Feature:
- Macro SRAM_RAND_DELAY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - The countdown loaded on push is LATENCY-1 + lfsr[1:0], adding 0..3 cycles.
  - addr_ok is additionally forced low when lfsr[4:2] == 3'b000.
  - Ordering and one-data_ok-per-cycle rules still hold: a younger entry whose count reaches 0 waits behind the head.
- Undefined: fixed latency exactly as above; no LFSR is instantiated.

Decomposition:
- Shared header (mycpu.h): SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings and the SRAM-like bus field widths, for reuse by EX/MEM stages and the bridge.
- One sub-module: resp_queue. It is a circular FIFO of OUTSTANDING entries with per-entry countdowns, push/pop, and count/full/head outputs.
- The top level holds the memory array, acceptance logic and the optional LFSR.

Test Plan:
- Reset, then write addr 0x10, wstrb 4'hF, wdata 0xDEADBEEF; read 0x10 next cycle -> first data_ok exactly LATENCY cycles after write acceptance with rdata 0; next cycle data_ok with rdata 0xDEADBEEF.
- Partial writes: word 0x20 = 0x11223344, then wstrb 4'b0010 with wdata 0x0000AA00 -> read returns 0x1122AA44; wstrb 0 write -> unchanged.
- Hold req high with LATENCY = 4, OUTSTANDING = 4 -> addr_ok drops after 4 accepts; first data_ok 4 cycles after the first accept; sustained 1 response per cycle; data order matches request order.
- Full queue plus head completing in the same cycle -> addr_ok stays 0 that cycle and returns 1 the next.
- Assert reset with 3 pending reads -> no data_ok afterwards, addr_ok = 1, earlier-written data still readable.
- Address 0x4010 with ADDR_W = 12 aliases 0x0010 (wrap) -> the read returns the same word.
